// File: rtl/e203_exu_div_wbck_buf.sv
`default_nettype none
// ============================================================================
//  Module   : e203_exu_div_wbck_buf
//  Purpose  : In-order result FIFO between the divider write-back port and the
//             final write-back arbiter. Optional same-cycle bypass when empty,
//             enabled by defining E203_DIV_WBCK_BUF_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module e203_exu_div_wbck_buf #(
  parameter int DW    = 32,
  parameter int TW    = 1,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  // divider side
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_wdat,
  input  logic [TW-1:0] i_itag,
  input  logic          i_err,
  // write-back arbiter side
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_wdat,
  output logic [TW-1:0] o_itag,
  output logic          o_err,
  // occupancy status
  output logic          buf_empty,
  output logic [AW:0]   buf_cnt
);

  localparam int          EW        = DW + TW + 1;
  localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  // Each entry is packed as {err, itag, wdat}
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_fifo_nonempty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_fifo_nonempty = (r_count != '0);
  // Depends on held state only, so o_ready never reaches i_ready
  assign i_ready         = (r_count != c_DEPTH);
  assign w_pop           = w_fifo_nonempty & o_ready;
  assign w_head          = r_mem[r_rd_ptr];

`ifdef E203_DIV_WBCK_BUF_BYPASS_EN
  logic w_bypass;

  // An empty buffer forwards the incoming result; it is stored only if the
  // arbiter does not take it this cycle.
  assign w_bypass = ~w_fifo_nonempty & i_valid;
  assign w_push   = i_valid & i_ready & ~(w_bypass & o_ready);
  assign o_valid  = w_fifo_nonempty | w_bypass;
  assign {o_err, o_itag, o_wdat} = w_bypass ? {i_err, i_itag, i_wdat} : w_head;
`else
  assign w_push   = i_valid & i_ready;
  assign o_valid  = w_fifo_nonempty;
  assign {o_err, o_itag, o_wdat} = w_head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_err, i_itag, i_wdat};
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      // DEPTH is a power of two, so pointers wrap by natural overflow
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign buf_empty = ~w_fifo_nonempty;
  assign buf_cnt   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_div_wbck_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e203_exu_div_wbck_buf
//  Purpose  : Self-checking bench for e203_exu_div_wbck_buf against a
//             queue-based reference model (honours E203_DIV_WBCK_BUF_BYPASS_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_e203_exu_div_wbck_buf;

  localparam int DW    = 32;
  localparam int TW    = 1;
  localparam int DEPTH = 2;
  localparam int AW    = 1;
`ifdef E203_DIV_WBCK_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_wdat = '0;
  logic [TW-1:0] i_itag = '0;
  logic          i_err = 1'b0;
  logic          o_ready = 1'b0;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_wdat;
  logic [TW-1:0] o_itag;
  logic          o_err;
  logic          buf_empty;
  logic [AW:0]   buf_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          err;
    logic [TW-1:0] itag;
    logic [DW-1:0] wdat;
  } ent_t;

  // Reference model: the results currently held, oldest first
  ent_t q[$];

  always #5 clk = ~clk;

  e203_exu_div_wbck_buf #(.DW(DW), .TW(TW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_wdat(i_wdat), .i_itag(i_itag), .i_err(i_err),
    .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_itag(o_itag), .o_err(o_err),
    .buf_empty(buf_empty), .buf_cnt(buf_cnt)
  );

  // Advance one clock and update the model from the inputs seen at the edge
  task automatic step();
    bit do_push;
    bit do_pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && o_ready;
      do_push = i_valid && (q.size() < DEPTH) && !(BYP && (q.size() == 0) && o_ready);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ent_t'({i_err, i_itag, i_wdat}));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [TW-1:0] t, input logic e);
    i_valid = v;
    i_wdat  = d;
    i_itag  = t;
    i_err   = e;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(1'b0, '0, '0, 1'b0); o_ready = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0h expected 0", o_valid); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %0h expected 1", i_ready); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_buf_empty: got %0h expected 1", buf_empty); end
    checks++; if (buf_cnt !== 2'd0) begin errors++; $display("FAIL reset_buf_cnt: got %0d expected 0", buf_cnt); end
    checks++; if ({o_err, o_itag, o_wdat} !== '0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", {o_err, o_itag, o_wdat}); end
    // reset in the middle of operation
    drive(1'b1, 32'h11, 1'b0, 1'b0); step();
    drive(1'b1, 32'h22, 1'b1, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (buf_cnt !== 2'd2) begin errors++; $display("FAIL midrst_pre_cnt: got %0d expected 2", buf_cnt); end
    rst = 1'b1; step(); rst = 1'b0; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid: got %0h expected 0", o_valid); end
    checks++; if (buf_cnt !== 2'd0) begin errors++; $display("FAIL midrst_buf_cnt: got %0d expected 0", buf_cnt); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL midrst_i_ready: got %0h expected 1", i_ready); end
    checks++; if (o_wdat !== 32'h0) begin errors++; $display("FAIL midrst_o_wdat: got %0h expected 0", o_wdat); end
    drive(1'b1, 32'h33, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (o_valid !== 1'b1 || o_wdat !== 32'h33) begin errors++; $display("FAIL midrst_first_after: got valid=%0h wdat=%0h expected valid=1 wdat=33", o_valid, o_wdat); end
    o_ready = 1'b1; step(); o_ready = 1'b0; #1;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL midrst_drain_empty: got %0h expected 1", buf_empty); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0007, 1'b1, 1'b0); o_ready = 1'b1; #1;
`ifdef E203_DIV_WBCK_BUF_BYPASS_EN
    checks++; if (o_valid !== 1'b1 || o_wdat !== 32'h7 || o_itag !== 1'b1) begin errors++; $display("FAIL single_bypass_out: got valid=%0h wdat=%0h itag=%0h expected 1/7/1", o_valid, o_wdat, o_itag); end
    step(); drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (buf_cnt !== 2'd0) begin errors++; $display("FAIL single_bypass_cnt: got %0d expected 0", buf_cnt); end
`else
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_no_early: got %0h expected 0", o_valid); end
    step(); drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (o_valid !== 1'b1 || o_wdat !== 32'h7 || o_itag !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL single_out: got valid=%0h wdat=%0h itag=%0h err=%0h expected 1/7/1/0", o_valid, o_wdat, o_itag, o_err); end
    step(); #1;
`endif
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %0h expected 1", buf_empty); end
    o_ready = 1'b0;
  endtask

  task automatic test_fill();
    o_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB, 1'b1, 1'b0); step();
    drive(1'b1, 32'hC, 1'b0, 1'b1); #1;
    checks++; if (buf_cnt !== 2'd2) begin errors++; $display("FAIL fill_cnt: got %0d expected 2", buf_cnt); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL fill_i_ready: got %0h expected 0", i_ready); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (o_valid !== 1'b1 || o_wdat !== 32'hA) begin errors++; $display("FAIL fill_hold_%0d: got valid=%0h wdat=%0h expected 1/a", k, o_valid, o_wdat); end
      step();
    end
    #1;
    checks++; if (buf_cnt !== 2'd2) begin errors++; $display("FAIL fill_no_accept: got %0d expected 2", buf_cnt); end
  endtask

  task automatic test_full_pop();
    o_ready = 1'b1; #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL fullpop_i_ready_same: got %0h expected 0", i_ready); end
    checks++; if (o_wdat !== 32'hA) begin errors++; $display("FAIL fullpop_head_a: got %0h expected a", o_wdat); end
    step(); o_ready = 1'b0; #1;
    checks++; if (buf_cnt !== 2'd1) begin errors++; $display("FAIL fullpop_c_not_taken: got %0d expected 1", buf_cnt); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL fullpop_i_ready_next: got %0h expected 1", i_ready); end
    checks++; if (o_wdat !== 32'hB) begin errors++; $display("FAIL fullpop_head_b: got %0h expected b", o_wdat); end
    step(); drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (buf_cnt !== 2'd2) begin errors++; $display("FAIL fullpop_c_pushed: got %0d expected 2", buf_cnt); end
    o_ready = 1'b1; step(); #1;
    checks++; if (o_wdat !== 32'hC || o_err !== 1'b1) begin errors++; $display("FAIL fullpop_head_c: got wdat=%0h err=%0h expected c/1", o_wdat, o_err); end
    step(); #1;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL fullpop_drained: got %0h expected 1", buf_empty); end
    o_ready = 1'b0;
  endtask

  task automatic test_wrap();
    ent_t got[$];
    ent_t cur;
    ent_t exp_e;
    int   sent = 0;
    int   cyc  = 0;
    while ((got.size() < 10) && (cyc < 200)) begin
      o_ready = ((cyc % 2) == 0);
      if (sent < 10) begin
        cur = ent_t'({((sent % 3) == 0), TW'(sent), DW'(sent + 1)});
        drive(1'b1, cur.wdat, cur.itag, cur.err);
      end else begin
        drive(1'b0, '0, '0, 1'b0);
      end
      #1;
      if (o_valid && o_ready) got.push_back(ent_t'({o_err, o_itag, o_wdat}));
      if ((sent < 10) && i_ready) sent++;
      step();
      cyc++;
    end
    drive(1'b0, '0, '0, 1'b0); o_ready = 1'b0;
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      exp_e = ent_t'({((k % 3) == 0), TW'(k), DW'(k + 1)});
      checks++; if (got[k] !== exp_e) begin errors++; $display("FAIL wrap_entry_%0d: got %0h expected %0h", k, got[k], exp_e); end
    end
  endtask

  task automatic test_error();
    o_ready = 1'b0;
    drive(1'b1, 32'h1234, 1'b1, 1'b0); step();
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0); #1;
    checks++; if (o_err !== 1'b0 || o_wdat !== 32'h1234) begin errors++; $display("FAIL err_first: got err=%0h wdat=%0h expected 0/1234", o_err, o_wdat); end
    o_ready = 1'b1; step(); #1;
    checks++; if (o_err !== 1'b1 || o_wdat !== 32'hFFFF_FFFF || o_itag !== 1'b0) begin errors++; $display("FAIL err_second: got err=%0h wdat=%0h itag=%0h expected 1/ffffffff/0", o_err, o_wdat, o_itag); end
    step(); o_ready = 1'b0; #1;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL err_drained: got %0h expected 1", buf_empty); end
  endtask

  task automatic test_random();
    bit   hold = 1'b0;
    bit   ev;
    ent_t eh;
    for (int c = 0; c < 400; c++) begin
      if (!hold) drive(($urandom_range(0, 3) != 0), DW'($urandom), TW'($urandom), 1'($urandom));
      o_ready = ($urandom_range(0, 2) != 0);
      #1;
      ev = (q.size() != 0) || (BYP && i_valid);
      eh = (q.size() != 0) ? q[0] : ent_t'({i_err, i_itag, i_wdat});
      checks++; if (o_valid !== ev) begin errors++; $display("FAIL rand_o_valid c=%0d: got %0h expected %0h", c, o_valid, ev); end
      checks++; if (i_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_i_ready c=%0d: got %0h expected %0h", c, i_ready, (q.size() < DEPTH)); end
      checks++; if (buf_cnt !== (AW+1)'(q.size())) begin errors++; $display("FAIL rand_buf_cnt c=%0d: got %0d expected %0d", c, buf_cnt, q.size()); end
      checks++; if (buf_empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_buf_empty c=%0d: got %0h expected %0h", c, buf_empty, (q.size() == 0)); end
      if (ev) begin
        checks++; if ({o_err, o_itag, o_wdat} !== eh) begin errors++; $display("FAIL rand_head c=%0d: got %0h expected %0h", c, {o_err, o_itag, o_wdat}, eh); end
      end
      hold = i_valid && !(q.size() < DEPTH);
      step();
    end
    drive(1'b0, '0, '0, 1'b0); o_ready = 1'b1;
    step(); step(); step();
    #1;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL rand_final_empty: got %0h expected 1", buf_empty); end
    o_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap();
    test_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
